// File: rtl/ps2_scancode_encoder_if.sv
// ---------------------------------------------------------------------------
// ps2_scancode_encoder_if
// Bundles the character-side and byte-side handshakes of the PS/2 scan-code
// encoder.
//   ascii_in / ascii_valid / ascii_ready : character input handshake
//   byte_out / byte_valid / byte_ready   : scan-code byte output handshake
//   unsupported                          : pulse, accepted char has no mapping
//   busy                                 : a scan-code sequence is in flight
// The slave modport is the encoder's view; master is the driver's view.
// ---------------------------------------------------------------------------
interface ps2_scancode_encoder_if;
   logic [7:0] ascii_in;
   logic       ascii_valid;
   logic       ascii_ready;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       byte_ready;
   logic       unsupported;
   logic       busy;

   modport master (
      output ascii_in, ascii_valid, byte_ready,
      input  ascii_ready, byte_out, byte_valid, unsupported, busy
   );

   modport slave (
      input  ascii_in, ascii_valid, byte_ready,
      output ascii_ready, byte_out, byte_valid, unsupported, busy
   );
endinterface

// File: rtl/ps2_scancode_encoder.sv
// ---------------------------------------------------------------------------
// ps2_scancode_encoder
// Turns one ASCII character into the PS/2 Set-2 byte stream a keyboard sends
// when the character is typed: make, F0, break, with Left-Shift make/break
// wrapped around shifted characters. Bytes leave on a valid/ready handshake
// with GAP_CYCLES idle cycles after every byte except the last.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-low reset
//   bus  : ps2_scancode_encoder_if.slave (character in, byte out, status)
// All outputs are registered; they are computed from the next state.
// ---------------------------------------------------------------------------
module ps2_scancode_encoder #(
   parameter logic [7:0]  SHIFT_CODE   = 8'h12,
   parameter logic [7:0]  BREAK_PREFIX = 8'hF0,
   parameter int unsigned GAP_CYCLES   = 2
) (
   input logic                  clk,
   input logic                  rst,
   ps2_scancode_encoder_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE, SH_MK, KEY_MK, KEY_PFX, KEY_BRK, SH_PFX, SH_BRK, GAP
   } state_t;

   localparam logic [7:0] GAP_INIT = 8'(GAP_CYCLES);

   // Letter index 0..25 (A..Z) to Set-2 make code.
   function automatic logic [7:0] letter_code(input logic [7:0] idx);
      logic [7:0] code;
      case (idx)
         8'd0:    code = 8'h1C;
         8'd1:    code = 8'h32;
         8'd2:    code = 8'h21;
         8'd3:    code = 8'h23;
         8'd4:    code = 8'h24;
         8'd5:    code = 8'h2B;
         8'd6:    code = 8'h34;
         8'd7:    code = 8'h33;
         8'd8:    code = 8'h43;
         8'd9:    code = 8'h3B;
         8'd10:   code = 8'h42;
         8'd11:   code = 8'h4B;
         8'd12:   code = 8'h3A;
         8'd13:   code = 8'h31;
         8'd14:   code = 8'h44;
         8'd15:   code = 8'h4D;
         8'd16:   code = 8'h15;
         8'd17:   code = 8'h2D;
         8'd18:   code = 8'h1B;
         8'd19:   code = 8'h2C;
         8'd20:   code = 8'h3C;
         8'd21:   code = 8'h2A;
         8'd22:   code = 8'h1D;
         8'd23:   code = 8'h22;
         8'd24:   code = 8'h35;
         8'd25:   code = 8'h1A;
         default: code = 8'h00;
      endcase
      return code;
   endfunction

   // Top-row digit 0..9 to Set-2 make code (also used by the shifted symbols).
   function automatic logic [7:0] digit_code(input logic [7:0] d);
      logic [7:0] code;
      case (d)
         8'd0:    code = 8'h45;
         8'd1:    code = 8'h16;
         8'd2:    code = 8'h1E;
         8'd3:    code = 8'h26;
         8'd4:    code = 8'h25;
         8'd5:    code = 8'h2E;
         8'd6:    code = 8'h36;
         8'd7:    code = 8'h3D;
         8'd8:    code = 8'h3E;
         8'd9:    code = 8'h46;
         default: code = 8'h00;
      endcase
      return code;
   endfunction

   // Returns {supported, shift, key_code} for a character.
   function automatic logic [9:0] map_ascii(input logic [7:0] c);
      logic [9:0] r;
      if (c >= 8'h61 && c <= 8'h7A) begin
         r = {2'b10, letter_code(c - 8'h61)};
      end else if (c >= 8'h41 && c <= 8'h5A) begin
         r = {2'b11, letter_code(c - 8'h41)};
      end else if (c >= 8'h30 && c <= 8'h39) begin
         r = {2'b10, digit_code(c - 8'h30)};
      end else begin
         case (c)
            8'h29:   r = {2'b11, digit_code(8'd0)};
            8'h21:   r = {2'b11, digit_code(8'd1)};
            8'h40:   r = {2'b11, digit_code(8'd2)};
            8'h23:   r = {2'b11, digit_code(8'd3)};
            8'h24:   r = {2'b11, digit_code(8'd4)};
            8'h25:   r = {2'b11, digit_code(8'd5)};
            8'h5E:   r = {2'b11, digit_code(8'd6)};
            8'h26:   r = {2'b11, digit_code(8'd7)};
            8'h2A:   r = {2'b11, digit_code(8'd8)};
            8'h28:   r = {2'b11, digit_code(8'd9)};
            8'h2D:   r = {2'b10, 8'h4E};
            8'h5F:   r = {2'b11, 8'h4E};
            8'h3D:   r = {2'b10, 8'h55};
            8'h2B:   r = {2'b11, 8'h55};
            default: r = 10'h000;
         endcase
      end
      return r;
   endfunction

   state_t     state_q, state_d;
   state_t     ret_q, ret_d;
   state_t     nxt_s;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] char_q, char_d;
   logic [7:0] byte_out_q, byte_out_d;
   logic       byte_valid_q, byte_valid_d;
   logic       ascii_ready_q, ascii_ready_d;
   logic       unsupported_q, unsupported_d;
   logic       busy_q, busy_d;

   logic [9:0] map_s;
   logic       sup_s;
   logic       shift_s;
   logic [7:0] key_s;
   logic       xfer_s;
   logic       last_s;

   // Character register: capture on any accept, hold otherwise.
   always_comb begin
      char_d = char_q;
      if (state_q == IDLE && bus.ascii_valid) begin
         char_d = bus.ascii_in;
      end else begin
         char_d = char_q;
      end
   end

   // Mapping of the held character (the fresh one on the accept cycle).
   assign map_s   = map_ascii(char_d);
   assign sup_s   = map_s[9];
   assign shift_s = map_s[8];
   assign key_s   = map_s[7:0];

   assign xfer_s = byte_valid_q && bus.byte_ready;
   // KEY_BRK ends an unshifted sequence; shifted ones continue to SH_PFX.
   assign last_s = (state_q == SH_BRK) || ((state_q == KEY_BRK) && !shift_s);

   // Emit state that follows the current one in the byte sequence.
   always_comb begin
      nxt_s = IDLE;
      case (state_q)
         SH_MK:   nxt_s = KEY_MK;
         KEY_MK:  nxt_s = KEY_PFX;
         KEY_PFX: nxt_s = KEY_BRK;
         KEY_BRK: nxt_s = SH_PFX;
         SH_PFX:  nxt_s = SH_BRK;
         default: nxt_s = IDLE;
      endcase
   end

   // Next-state logic: accept, emit/hold, gap countdown.
   always_comb begin
      state_d       = state_q;
      ret_d         = ret_q;
      cnt_d         = cnt_q;
      unsupported_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.ascii_valid) begin
               if (sup_s) begin
                  if (shift_s) begin
                     state_d = SH_MK;
                  end else begin
                     state_d = KEY_MK;
                  end
               end else begin
                  unsupported_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         GAP: begin
            // Loaded with GAP_CYCLES; leaving at 1 yields exactly that many idle cycles.
            if (cnt_q <= 8'd1) begin
               state_d = ret_q;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         SH_MK, KEY_MK, KEY_PFX, KEY_BRK, SH_PFX, SH_BRK: begin
            if (xfer_s) begin
               if (last_s) begin
                  state_d = IDLE;
               end else if (GAP_CYCLES != 32'd0) begin
                  state_d = GAP;
                  cnt_d   = GAP_INIT;
                  ret_d   = nxt_s;
               end else begin
                  state_d = nxt_s;
               end
            end else begin
               state_d = state_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output values for the state being entered, so outputs can be registered.
   always_comb begin
      byte_valid_d = 1'b1;
      byte_out_d   = 8'h00;
      case (state_d)
         SH_MK, SH_BRK:    byte_out_d = SHIFT_CODE;
         KEY_MK, KEY_BRK:  byte_out_d = key_s;
         KEY_PFX, SH_PFX:  byte_out_d = BREAK_PREFIX;
         default: begin
            byte_valid_d = 1'b0;
            byte_out_d   = 8'h00;
         end
      endcase
      ascii_ready_d = (state_d == IDLE);
      busy_d        = (state_d != IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= IDLE;
         ret_q         <= IDLE;
         cnt_q         <= 8'h00;
         char_q        <= 8'h00;
         byte_out_q    <= 8'h00;
         byte_valid_q  <= 1'b0;
         ascii_ready_q <= 1'b1;
         unsupported_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         ret_q         <= ret_d;
         cnt_q         <= cnt_d;
         char_q        <= char_d;
         byte_out_q    <= byte_out_d;
         byte_valid_q  <= byte_valid_d;
         ascii_ready_q <= ascii_ready_d;
         unsupported_q <= unsupported_d;
         busy_q        <= busy_d;
      end
   end

   assign bus.byte_out    = byte_out_q;
   assign bus.byte_valid  = byte_valid_q;
   assign bus.ascii_ready = ascii_ready_q;
   assign bus.unsupported = unsupported_q;
   assign bus.busy        = busy_q;

endmodule
